// File: rtl/as6500_meas_sched.sv
// AS6500 shot scheduler: arms a measurement window per angle step, waits for the TDC
// interrupt, hands off to the SPI reader and keeps shot/timeout counters.
module as6500_meas_sched #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        i_clk_100m,
  input  logic        i_rst_n,
  input  logic        i_cfg_done,
  input  logic        i_motor_state,
  input  logic        i_angle_sync,
  input  logic        i_tdc_intn,
  input  logic        i_read_ack,
  input  logic        i_read_done,
  input  logic        i_cnt_clr,
  output logic        o_meas_en,
  output logic        o_frame_start,
  output logic        o_read_req,
  output logic        o_timeout_err,
  output logic        o_overrun,
  output logic [15:0] o_shot_cnt,
  output logic [7:0]  o_err_cnt,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_INT = 3'd2,
    REQ      = 3'd3,
    READ     = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        intn_m, intn_s, angle_d;
  logic [15:0] timer;
  logic [15:0] shot_cnt;
  logic [7:0]  err_cnt;
  logic        angle_edge, run_ok, shot_done, tmo_hit;

  // Reset to 1: interrupt idle, and a level already high at release is not an edge.
  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      intn_m  <= 1'b1;
      intn_s  <= 1'b1;
      angle_d <= 1'b1;
    end else begin
      intn_m  <= i_tdc_intn;
      intn_s  <= intn_m;
      angle_d <= i_angle_sync;
    end
  end

  assign angle_edge = i_angle_sync & ~angle_d;
  assign run_ok     = i_cfg_done & i_motor_state;
  assign shot_done  = ((state == READ) && i_read_done) ||
                      ((state == REQ) && i_read_ack && i_read_done);
  // Abort and interrupt both take precedence over the window timeout.
  assign tmo_hit    = ((state == WAIT_INT) && run_ok && intn_s && (timer == TMO_LAST)) ||
                      ((state == READ) && !i_read_done && (timer == TMO_LAST));

  // The ARM cycle counts as timer tick 0, so the window expires TIMEOUT_CYC cycles after ARM.
  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      o_meas_en     <= 1'b0;
      o_frame_start <= 1'b0;
      o_read_req    <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overrun     <= angle_edge && (state != IDLE);
      case (state)
        IDLE: begin
          o_meas_en  <= 1'b0;
          o_read_req <= 1'b0;
          if (angle_edge && run_ok) begin
            state         <= ARM;
            o_frame_start <= 1'b1;
            o_meas_en     <= 1'b1;
            timer         <= '0;
          end
        end
        ARM: begin
          if (!run_ok) begin
            state     <= IDLE;
            o_meas_en <= 1'b0;
          end else begin
            state <= WAIT_INT;
            timer <= timer + 16'd1;
          end
        end
        WAIT_INT: begin
          if (!run_ok) begin
            state     <= IDLE;
            o_meas_en <= 1'b0;
          end else if (!intn_s) begin
            state      <= REQ;
            o_meas_en  <= 1'b0;
            o_read_req <= 1'b1;
          end else if (tmo_hit) begin
            state         <= IDLE;
            o_meas_en     <= 1'b0;
            o_timeout_err <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        REQ: begin
          if (i_read_ack) begin
            o_read_req <= 1'b0;
            timer      <= '0;
            state      <= i_read_done ? IDLE : READ;
          end
        end
        READ: begin
          if (i_read_done) begin
            state <= IDLE;
          end else if (tmo_hit) begin
            state         <= IDLE;
            o_timeout_err <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          o_meas_en  <= 1'b0;
          o_read_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shot_cnt <= '0;
      err_cnt  <= '0;
    end else if (i_cnt_clr) begin
      shot_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (shot_done)                  shot_cnt <= shot_cnt + 16'd1;
      if (tmo_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_shot_cnt = shot_cnt;
  assign o_err_cnt  = err_cnt;
  assign o_state    = state;

endmodule

// File: tb/tb_as6500_meas_sched.sv
// Directed bench for as6500_meas_sched: shot flow, timeouts, aborts, overrun,
// counter wrap/saturate/clear and mid-transaction reset.
module tb_as6500_meas_sched;

  logic        clk = 1'b0;
  logic        rst_n, cfg_done, motor_state, angle_sync, tdc_intn;
  logic        read_ack, read_done, cnt_clr;
  logic        meas_en, frame_start, read_req, timeout_err, overrun;
  logic [15:0] shot_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  as6500_meas_sched #(.TIMEOUT_CYC(1000)) dut (
    .i_clk_100m    (clk),
    .i_rst_n       (rst_n),
    .i_cfg_done    (cfg_done),
    .i_motor_state (motor_state),
    .i_angle_sync  (angle_sync),
    .i_tdc_intn    (tdc_intn),
    .i_read_ack    (read_ack),
    .i_read_done   (read_done),
    .i_cnt_clr     (cnt_clr),
    .o_meas_en     (meas_en),
    .o_frame_start (frame_start),
    .o_read_req    (read_req),
    .o_timeout_err (timeout_err),
    .o_overrun     (overrun),
    .o_shot_cnt    (shot_cnt),
    .o_err_cnt     (err_cnt),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Angle edge, then interrupt pin low right away: ends with the block in REQ.
  task automatic to_req();
    angle_sync = 1'b1;
    tick(1);
    angle_sync = 1'b0;
    tdc_intn   = 1'b0;
    tick(3);
    tdc_intn   = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; cfg_done = 1'b1; motor_state = 1'b1; angle_sync = 1'b0;
    tdc_intn = 1'b1; read_ack = 1'b0; read_done = 1'b0; cnt_clr = 1'b0;
    tick(2);
    chk("rst_state", state, 3'd0);
    chk("rst_meas_en", meas_en, 1'b0);
    chk("rst_read_req", read_req, 1'b0);
    chk("rst_shot", shot_cnt, 16'd0);
    chk("rst_err", err_cnt, 8'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic shot: frame at N+1, read_req at M+3
    angle_sync = 1'b1;
    tick(1);
    chk("arm_frame", frame_start, 1'b1);
    chk("arm_meas_en", meas_en, 1'b1);
    chk("arm_state", state, 3'd1);
    angle_sync = 1'b0;
    tick(1);
    chk("wait_frame_off", frame_start, 1'b0);
    chk("wait_state", state, 3'd2);
    tdc_intn = 1'b0;
    tick(2);
    chk("m2_meas_en", meas_en, 1'b1);
    tick(1);
    chk("m3_meas_en", meas_en, 1'b0);
    chk("m3_read_req", read_req, 1'b1);
    chk("m3_state", state, 3'd3);
    tdc_intn = 1'b1;
    tick(2);
    chk("req_hold", read_req, 1'b1);
    read_ack = 1'b1;
    tick(1);
    read_ack = 1'b0;
    chk("read_state", state, 3'd4);
    chk("read_req_clr", read_req, 1'b0);
    tick(3);
    read_done = 1'b1;
    tick(1);
    read_done = 1'b0;
    chk("shot1_state", state, 3'd0);
    chk("shot1_cnt", shot_cnt, 16'd1);

    // Edge with cfg_done low is dropped
    cfg_done = 1'b0; angle_sync = 1'b1;
    tick(1);
    chk("cfg_low_state", state, 3'd0);
    chk("cfg_low_frame", frame_start, 1'b0);
    angle_sync = 1'b0; cfg_done = 1'b1;
    tick(1);

    // Wait-window timeout: 1000 cycles after ARM
    angle_sync = 1'b1;
    tick(1);
    angle_sync = 1'b0;
    tick(999);
    chk("tmo_early", timeout_err, 1'b0);
    chk("tmo_early_state", state, 3'd2);
    tick(1);
    chk("tmo_pulse", timeout_err, 1'b1);
    chk("tmo_err_cnt", err_cnt, 8'd1);
    chk("tmo_state", state, 3'd0);
    chk("tmo_meas_en", meas_en, 1'b0);
    tick(1);
    chk("tmo_pulse_end", timeout_err, 1'b0);

    // Motor drop in WAIT_INT aborts with no counter change
    angle_sync = 1'b1;
    tick(1);
    angle_sync = 1'b0;
    tick(1);
    motor_state = 1'b0;
    tick(1);
    chk("abort_state", state, 3'd0);
    chk("abort_meas_en", meas_en, 1'b0);
    tick(1);
    chk("abort_no_err", timeout_err, 1'b0);
    chk("abort_shot", shot_cnt, 16'd1);
    chk("abort_err", err_cnt, 8'd1);
    motor_state = 1'b1;

    // Motor drop and angle edge during READ
    to_req();
    read_ack = 1'b1;
    tick(1);
    read_ack = 1'b0; motor_state = 1'b0;
    tick(2);
    chk("read_motor_off", state, 3'd4);
    angle_sync = 1'b1;
    tick(1);
    chk("overrun_pulse", overrun, 1'b1);
    chk("overrun_no_frame", frame_start, 1'b0);
    angle_sync = 1'b0;
    tick(1);
    chk("overrun_end", overrun, 1'b0);
    read_done = 1'b1;
    tick(1);
    read_done = 1'b0; motor_state = 1'b1;
    chk("read_motor_shot", shot_cnt, 16'd2);

    // ack and done together in REQ
    to_req();
    read_ack = 1'b1; read_done = 1'b1;
    tick(1);
    read_ack = 1'b0; read_done = 1'b0;
    chk("ackdone_state", state, 3'd0);
    chk("ackdone_shot", shot_cnt, 16'd3);

    // Shot counter wrap
    force dut.shot_cnt = 16'hFFFF;
    tick(1);
    release dut.shot_cnt;
    tick(1);
    chk("preload_shot", shot_cnt, 16'hFFFF);
    to_req();
    read_ack = 1'b1; read_done = 1'b1;
    tick(1);
    read_ack = 1'b0; read_done = 1'b0;
    chk("wrap_shot", shot_cnt, 16'h0000);

    // Error counter saturation
    force dut.err_cnt = 8'hFE;
    tick(1);
    release dut.err_cnt;
    for (int k = 0; k < 2; k++) begin
      angle_sync = 1'b1;
      tick(1);
      angle_sync = 1'b0;
      tick(1000);
      chk("sat_pulse", timeout_err, 1'b1);
      chk("sat_err", err_cnt, 8'hFF);
    end

    // Clear coincident with completion: clear wins
    to_req();
    read_ack = 1'b1; read_done = 1'b1; cnt_clr = 1'b1;
    tick(1);
    read_ack = 1'b0; read_done = 1'b0; cnt_clr = 1'b0;
    chk("clr_shot", shot_cnt, 16'd0);
    chk("clr_err", err_cnt, 8'd0);

    // Reset mid-READ, angle held high across release
    to_req();
    read_ack = 1'b1;
    tick(1);
    read_ack = 1'b0;
    chk("prerst_state", state, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", state, 3'd0);
    chk("rst_async_err", timeout_err, 1'b0);
    angle_sync = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rel_high_state", state, 3'd0);
    chk("rel_high_frame", frame_start, 1'b0);
    angle_sync = 1'b0;
    tick(1);
    angle_sync = 1'b1;
    tick(1);
    chk("rel_new_edge", frame_start, 1'b1);
    angle_sync = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/as6500_meas_sched.md
AS6500_MEAS_SCHED -- requirements
Module: as6500_meas_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000, the watchdog limit in clock cycles for WAIT_INT and READ (10 us at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port i_clk_100m, in, 1: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port i_rst_n, in, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port i_cfg_done, in, 1: level; TDC register configuration complete.
REQ-005 SHALL have port i_motor_state, in, 1: level; motor speed locked.
REQ-006 SHALL have port i_angle_sync, in, 1: synchronous level; each rising edge marks one angle step.
REQ-007 SHALL have port i_tdc_intn, in, 1: AS6500 INTERRUPT, active-low, asynchronous to the clock.
REQ-008 SHALL have port i_read_ack, in, 1: one-cycle pulse; the SPI reader has accepted the request.
REQ-009 SHALL have port i_read_done, in, 1: one-cycle pulse; the SPI readout is finished.
REQ-010 SHALL have port i_cnt_clr, in, 1: one-cycle pulse that clears both counters.
REQ-011 SHALL have port o_meas_en, out, 1: measurement window enable for the laser/stop path.
REQ-012 SHALL have port o_frame_start, out, 1: one-cycle pulse at the start of each shot.
REQ-013 SHALL have port o_read_req, out, 1: readout request level.
REQ-014 SHALL have port o_timeout_err, out, 1: one-cycle pulse on watchdog expiry.
REQ-015 SHALL have port o_overrun, out, 1: one-cycle pulse when an angle edge arrives while busy.
REQ-016 SHALL have port o_shot_cnt, out, 16: count of completed shots.
REQ-017 SHALL have port o_err_cnt, out, 8: count of timeouts.
REQ-018 SHALL have port o_state, out, 3: current FSM state code, for debug.

Function
REQ-019 SHALL pass i_tdc_intn through a 2-flop synchronizer; only the synchronized signal is used, so it lags the pin by 2 cycles.
REQ-020 SHALL detect an angle edge as i_angle_sync high in the current cycle while its registered copy from the previous cycle is low.
REQ-021 SHALL implement the FSM states IDLE=0, ARM=1, WAIT_INT=2, REQ=3, READ=4; all outputs are registered.
REQ-022 IDLE -> ARM on an angle edge while i_cfg_done=1 and i_motor_state=1; an edge that arrives while either is low is dropped silently.
REQ-023 ARM SHALL last exactly 1 cycle: o_frame_start=1, o_meas_en=1, watchdog timer cleared to 0; then -> WAIT_INT.
REQ-024 WAIT_INT SHALL hold o_meas_en=1 and increment the timer every cycle.
- synchronized intn=0 -> REQ, o_meas_en=0.
- timer=TIMEOUT_CYC-1 -> IDLE, with o_timeout_err pulsed in the transition cycle.
- intn=0 and timer expiry in the same cycle -> intn wins, no error.
REQ-025 In ARM or WAIT_INT, i_motor_state=0 or i_cfg_done=0 SHALL abort to IDLE on the next cycle: o_meas_en=0, no counter change, no error.
REQ-026 REQ SHALL hold o_read_req=1 until i_read_ack=1, then clear it and -> READ; REQ has no timeout and cannot be aborted.
REQ-027 READ SHALL run the watchdog from 0.
- i_read_done=1 -> IDLE, o_shot_cnt+1.
- timer expiry -> IDLE with o_timeout_err.
- i_motor_state and i_cfg_done are ignored in REQ and READ, so an SPI transfer is never cut mid-way.
REQ-028 i_read_ack and i_read_done in the same cycle while in REQ SHALL be treated as a completed shot: -> IDLE, o_shot_cnt+1.
REQ-029 An angle edge in any state other than IDLE SHALL pulse o_overrun and be discarded; it is not queued.
REQ-030 o_shot_cnt SHALL wrap from 0xFFFF to 0; o_err_cnt SHALL saturate at 0xFF.
REQ-031 i_cnt_clr SHALL zero both counters on the next cycle; when it coincides with an increment, the clear wins.
REQ-032 Timer width SHALL be 16 bits; comparisons are unsigned.

Reset
REQ-033 While i_rst_n=0 the block SHALL hold:
- state IDLE, all pulses and levels 0, counters 0, timer 0;
- both synchronizer flops set to 1 (interrupt inactive);
- the angle-edge register set to 1, so a level that is high at reset release is not taken as an edge.
REQ-034 Reset asserted mid-transaction SHALL abandon it at once with no error pulse; the first edge accepted after release is a new rising edge.

Verification
REQ-035 cfg_done=1, motor=1, angle rises at cycle N -> o_frame_start=1 and o_meas_en=1 at N+1; tdc_intn pin low at M -> o_meas_en=0 and o_read_req=1 from M+3; ack then done -> o_shot_cnt=1.
REQ-036 Shot started with tdc_intn held high, TIMEOUT_CYC=1000 -> exactly 1000 cycles after ARM: o_timeout_err one pulse, o_err_cnt=1, state=IDLE.
REQ-037 Motor drops during WAIT_INT -> IDLE, counters unchanged; motor drops during READ -> transfer completes and o_shot_cnt increments.
REQ-038 Angle edge during READ -> o_overrun one pulse, no second frame_start; ack and done in the same cycle -> o_shot_cnt+1.
REQ-039 Preload o_shot_cnt to 0xFFFF and complete one shot -> 0x0000; 256 timeouts -> o_err_cnt=0xFF; i_cnt_clr coincident with done -> both counters 0.
REQ-040 Reset pulse mid-READ -> all outputs 0 immediately; angle held high at release -> no shot until the next rising edge.
